// File: rtl/p_bus_arbiter_if.sv
// Shared-bus handshake bundle between NB_INS requesters, the arbiter and the bus consumer.
interface p_bus_arbiter_if #(
    parameter int unsigned BUS_WIDTH = 4,
    parameter int unsigned NB_INS    = 3
);
    logic [NB_INS-1:0]           req;
    logic [NB_INS-1:0]           in_last;
    logic [NB_INS*BUS_WIDTH-1:0] in_buses;
    logic [NB_INS-1:0]           in_ack;
    logic [NB_INS-1:0]           grant;
    logic [BUS_WIDTH-1:0]        out_bus;
    logic                        out_valid;
    logic                        out_last;
    logic                        out_ready;

    // Requesters and consumer side.
    modport master (
        output req, in_last, in_buses, out_ready,
        input  in_ack, grant, out_bus, out_valid, out_last
    );

    // Arbiter side.
    modport slave (
        input  req, in_last, in_buses, out_ready,
        output in_ack, grant, out_bus, out_valid, out_last
    );
endinterface

// File: rtl/p_bus_arbiter.sv
// Round-robin burst arbiter: merges the granted requester's slice onto a
// registered valid/ready output stage, holding grant until last beat or MAX_BURST.
module p_bus_arbiter #(
    parameter int unsigned BUS_WIDTH = 4,
    parameter int unsigned NB_INS    = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    p_bus_arbiter_if.slave    bus
);

    localparam int unsigned PTR_W = (NB_INS > 1) ? $clog2(NB_INS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state;
    logic [NB_INS-1:0]    grant_q;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     ptr;
    logic [CNT_W-1:0]     beat_cnt;
    logic [BUS_WIDTH-1:0] out_bus_q;
    logic                 out_valid_q;
    logic                 out_last_q;

    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [BUS_WIDTH-1:0] merged;
    logic [NB_INS-1:0]    ack_vec;
    logic                 ack_any;
    logic                 rel_beat;
    logic [PTR_W-1:0]     ptr_next;

    // Round-robin search starting at ptr, wrapping mod NB_INS.
    always_comb begin : arb_search
        logic [PTR_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NB_INS; k++) begin
            cand = PTR_W'((32'(ptr) + k) % NB_INS);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant-gated AND/OR merge of all requester slices.
    always_comb begin
        merged = '0;
        for (int unsigned j = 0; j < NB_INS; j++) begin
            merged = merged | (bus.in_buses[j*BUS_WIDTH +: BUS_WIDTH] & {BUS_WIDTH{grant_q[j]}});
        end
    end

    // Beat acceptance; grant is zero in IDLE so no ack can occur there.
    always_comb begin
        ack_vec  = grant_q & bus.req & {NB_INS{~out_valid_q | bus.out_ready}};
        ack_any  = |ack_vec;
        rel_beat = ack_any & ((|(ack_vec & bus.in_last)) ||
                              (beat_cnt == CNT_W'(MAX_BURST - 1)));
        ptr_next = (gnt_idx == PTR_W'(NB_INS - 1)) ? '0 : PTR_W'(gnt_idx + 1'b1);
    end

    // Arbitration FSM and output register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_q     <= '0;
            gnt_idx     <= '0;
            ptr         <= '0;
            beat_cnt    <= '0;
            out_bus_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_q  <= NB_INS'(1) << win_idx;
                        gnt_idx  <= win_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack_any) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (rel_beat) begin
                            grant_q <= '0;
                            ptr     <= ptr_next;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Output stage: load on ack, otherwise drain when consumer is ready.
            if (ack_any) begin
                out_bus_q   <= merged;
                out_valid_q <= 1'b1;
                out_last_q  <= rel_beat;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ack    = ack_vec;
    assign bus.grant     = grant_q;
    assign bus.out_bus   = out_bus_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: doc/p_bus_arbiter.md
# p_bus_arbiter

Round-robin arbiter and output register that shares one BUS_WIDTH-bit bus among NB_INS requesters. Each requester presents data on its slice of in_buses with req; the granted slice is merged onto the shared bus by a masked AND/OR reduction (grant-gated p_or style merge) and captured into a valid/ready output stage. Transfers may be multi-beat bursts that hold the grant until a last beat or a MAX_BURST limit. It sits between the register-file/ALU drivers and the shared CPU data bus.

## Interface
- BUS_WIDTH, 4, width of each data bus
- NB_INS, 3, number of requesters (≥2)
- MAX_BURST, 4, maximum beats per grant before forced release (≥1)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req  input  NB_INS  request per requester
- in_last  input  NB_INS  per-requester last-beat flag
- in_buses  input  NB_INS*BUS_WIDTH  flattened data; requester i occupies bits [i*BUS_WIDTH +: BUS_WIDTH]
- in_ack  output  NB_INS  combinational, one-hot or zero: beat of requester i accepted this cycle
- grant  output  NB_INS  registered one-hot grant, zero when idle
- out_bus  output  BUS_WIDTH  registered merged data
- out_valid  output  1  out_bus holds an unconsumed beat
- out_last  output  1  qualifies out_bus as final beat of a grant
- out_ready  input  1  consumer accepts out_bus when out_valid & out_ready

## Operation
- States: IDLE, GRANT. Reset: state IDLE, grant 0, out_bus 0, out_valid 0, out_last 0, ptr 0, beat_cnt 0.
- IDLE: if req nonzero, winner = first i with req[i] searching ptr, ptr+1, … wrapping mod NB_INS; grant <= onehot(winner), beat_cnt <= 0, go GRANT. If req zero, stay.
- in_ack[i] = grant[i] & req[i] & (~out_valid | out_ready). Never asserted in IDLE.
- On ack: out_bus <= OR over j of (in_buses slice j AND {BUS_WIDTH{grant[j]}}); out_valid <= 1; beat_cnt <= beat_cnt+1.
- Release beat: ack with in_last[i]=1 or beat_cnt == MAX_BURST-1. On release: out_last <= 1, grant <= 0, ptr <= (i+1) mod NB_INS, go IDLE. Non-release ack: out_last <= 0.
- No ack and out_ready: out_valid <= 0, out_last <= 0.
- GRANT with req[i] low: grant held, no ack, beat_cnt unchanged; no timeout.
- Requests of non-granted requesters ignored until next IDLE arbitration; they must hold req.
- in_last and data of non-granted requesters have no effect on any output.

## Timing
- Arbitration latency: req sampled in IDLE at edge N → grant high after edge N; earliest in_ack same cycle; out_valid high after edge N+1.
- Back-to-back beats: one beat per cycle while out_ready=1 (ack and drain in same cycle).
- Backpressure: out_valid=1 and out_ready=0 → in_ack 0, out_bus/out_valid/out_last stable.
- Exactly one IDLE cycle between successive grants; out stage may still drain during it.
- beat_cnt width ceil(log2(MAX_BURST))+1; MAX_BURST=1 makes every beat a release beat.
- ptr wraps NB_INS-1 → 0.
- rst_n low at any edge, incl. mid-burst: all state to reset values at that edge; in_ack 0 while grant 0; pending beat lost.

## Test plan
- Reset: rst_n low 2 cycles, req=3'b111 → grant 0, out_valid 0, out_bus 4'b0000, in_ack 0 throughout reset.
- Single beat: req=3'b010, in_buses slice1=4'b1011, in_last[1]=1, out_ready=1 → grant 3'b010 one cycle, in_ack[1] same cycle, next cycle out_bus=1011, out_valid=1, out_last=1, then grant 0.
- Round robin: req=3'b111 held, all in_last=1, slices 1001/1011/0110 → grant order 001,010,100,001; out_bus 1001,1011,0110,1001, one idle cycle between grants.
- Burst + forced release: req=3'b001, in_last=0, MAX_BURST=4, data 1..5 per beat → 4 acks, out_last=1 only on 4th (0100), grant drops, requester 0 regranted after IDLE cycle.
- Backpressure: mid-burst out_ready=0 for 3 cycles → in_ack 0, out_bus unchanged, out_valid=1; on out_ready=1 next beat accepted same cycle.
- Reset mid-burst: rst_n low during beat 2 of burst → next cycle grant 0, out_valid 0, ptr 0; after release req=3'b110 grants requester 1 first.
